// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - register map, control words and FSM states for the SHA256 accelerator host driver
package acc_pkg;

    localparam logic [4:0]  ACC_ADDR_CTRL = 5'd16;
    localparam logic [4:0]  ACC_ADDR_DONE = 5'd17;

    localparam logic [31:0] CTRL_START    = 32'hFFFF_FFFF;
    localparam logic [31:0] CTRL_SOFT_RST = 32'hFF00_00FF;
    localparam logic [31:0] CTRL_ACK      = 32'h0F0F_0F0F;
    localparam logic [31:0] DONE_FLAG     = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_POLL,
        ST_ABORT,
        ST_ABORT_WAIT,
        ST_READ,
        ST_ACK,
        ST_SETTLE,
        ST_OUT
    } acc_state_t;

endpackage

// File: rtl/acc_host_driver.sv
// rtl/acc_host_driver.sv - Avalon-MM initiator running the SHA256 accelerator job protocol with timeout recovery
module acc_host_driver
    import acc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRY      = 2,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         hash_valid,
    input  logic         hash_ready,
    output logic [255:0] hash_data,
    output logic         hash_err,
    output logic         busy,
    output logic [4:0]   avm_address,
    output logic         avm_chipselect,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic [31:0]  avm_readdata
);

    acc_state_t   state_q, state_d;
    logic [511:0] blk_q;
    logic [255:0] hash_q;
    logic         err_q;
    logic [3:0]   word_q;
    logic [15:0]  cnt_q;
    logic [7:0]   retry_q;
    logic [2:0]   rd_idx;

    logic accept, word_clr, word_inc, cnt_clr, cnt_inc, retry_inc, capture, fail;

    // Read data lags the address by one cycle, so READ cycle j stores word j-1.
    assign rd_idx = word_q[2:0] - 3'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        avm_address   = '0;
        avm_write     = 1'b0;
        avm_writedata = '0;
        accept        = 1'b0;
        word_clr      = 1'b0;
        word_inc      = 1'b0;
        cnt_clr       = 1'b0;
        cnt_inc       = 1'b0;
        retry_inc     = 1'b0;
        capture       = 1'b0;
        fail          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (blk_valid) begin
                    accept   = 1'b1;
                    word_clr = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                avm_address   = {1'b0, word_q};
                avm_write     = 1'b1;
                avm_writedata = blk_q[{word_q, 5'd0} +: 32];
                if (word_q == 4'd15) state_d  = ST_START;
                else                 word_inc = 1'b1;
            end
            ST_START: begin
                avm_address   = ACC_ADDR_CTRL;
                avm_write     = 1'b1;
                avm_writedata = CTRL_START;
                cnt_clr       = 1'b1;
                state_d       = ST_POLL;
            end
            ST_POLL: begin
                avm_address = ACC_ADDR_DONE;
                // DONE wins over a timeout landing on the same cycle.
                if (avm_readdata == DONE_FLAG) begin
                    word_clr = 1'b1;
                    state_d  = ST_READ;
                end else if (cnt_q >= 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_ABORT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_ABORT: begin
                avm_address   = ACC_ADDR_CTRL;
                avm_write     = 1'b1;
                avm_writedata = CTRL_SOFT_RST;
                state_d       = ST_ABORT_WAIT;
            end
            ST_ABORT_WAIT: begin
                if (retry_q < 8'(MAX_RETRY)) begin
                    retry_inc = 1'b1;
                    state_d   = ST_START;
                end else begin
                    fail    = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_READ: begin
                avm_address = {2'b00, word_q[2:0]};
                capture     = (word_q != 4'd0);
                if (word_q == 4'd8) state_d  = ST_ACK;
                else                word_inc = 1'b1;
            end
            ST_ACK: begin
                avm_address   = ACC_ADDR_CTRL;
                avm_write     = 1'b1;
                avm_writedata = CTRL_ACK;
                cnt_clr       = 1'b1;
                state_d       = (SETTLE_CYCLES == 0) ? ST_OUT : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q >= 16'(SETTLE_CYCLES - 1)) state_d = ST_OUT;
                else                                 cnt_inc = 1'b1;
            end
            ST_OUT: begin
                if (hash_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blk_q   <= '0;
            hash_q  <= '0;
            err_q   <= 1'b0;
            word_q  <= '0;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            if (accept) begin
                blk_q   <= blk_data;
                retry_q <= '0;
                err_q   <= 1'b0;
            end
            if (word_clr)                          word_q <= '0;
            else if (word_inc && word_q != 4'hF)   word_q <= word_q + 4'd1;
            if (cnt_clr)                           cnt_q  <= '0;
            else if (cnt_inc && cnt_q != 16'hFFFF) cnt_q  <= cnt_q + 16'd1;
            if (retry_inc && retry_q != 8'hFF)     retry_q <= retry_q + 8'd1;
            if (capture)                           hash_q[{rd_idx, 5'd0} +: 32] <= avm_readdata;
            if (fail) begin
                err_q  <= 1'b1;
                hash_q <= '0;
            end
        end
    end

    assign avm_chipselect = avm_write;
    assign blk_ready      = (state_q == ST_IDLE) && reset_n;
    assign busy           = (state_q != ST_IDLE);
    assign hash_valid     = (state_q == ST_OUT);
    assign hash_data      = hash_valid ? hash_q : '0;
    assign hash_err       = hash_valid & err_q;

endmodule

// File: tb/tb_acc_host_driver.sv
// tb/tb_acc_host_driver.sv - scoreboard bench for acc_host_driver with a behavioural accelerator slave
module tb_acc_host_driver;
    import acc_pkg::*;

    localparam int TIMEOUT = 32;
    localparam int RETRIES = 2;
    localparam int SETTLE  = 2;

    logic         clk;
    logic         reset_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         hash_valid;
    logic         hash_ready;
    logic [255:0] hash_data;
    logic         hash_err;
    logic         busy;
    logic [4:0]   avm_address;
    logic         avm_chipselect;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic [31:0]  avm_readdata;

    acc_host_driver #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .MAX_RETRY(RETRIES),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .blk_valid(blk_valid),
        .blk_ready(blk_ready),
        .blk_data(blk_data),
        .hash_valid(hash_valid),
        .hash_ready(hash_ready),
        .hash_data(hash_data),
        .hash_err(hash_err),
        .busy(busy),
        .avm_address(avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] hash;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mk_blk(input logic [31:0] base);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = base + i;
        return r;
    endfunction

    function automatic logic [255:0] mk_hash(input logic [31:0] seed);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = seed + i;
        return r;
    endfunction

    // Accelerator model: DONE becomes visible on poll cycle m_lat+2 after START.
    logic [31:0] m_seed;
    int          m_lat;
    int          m_hang_until;
    logic        m_run;
    int          m_cnt;
    int          m_start_total = 0;
    logic        m_done;
    assign m_done = m_run && (m_cnt == 0);

    always @(posedge clk) begin
        if (!reset_n) begin
            m_run        <= 1'b0;
            m_cnt        <= 0;
            avm_readdata <= '0;
        end else begin
            if (m_cnt > 0) m_cnt <= m_cnt - 1;
            if (avm_write && avm_chipselect && avm_address == ACC_ADDR_CTRL) begin
                if (avm_writedata == CTRL_START) begin
                    m_start_total <= m_start_total + 1;
                    if (m_start_total >= m_hang_until) begin
                        m_run <= 1'b1;
                        m_cnt <= m_lat;
                    end
                end else if (avm_writedata == CTRL_SOFT_RST || avm_writedata == CTRL_ACK) begin
                    m_run <= 1'b0;
                end
            end
            if (avm_address == ACC_ADDR_DONE)  avm_readdata <= m_done ? DONE_FLAG : 32'h0;
            else if (avm_address < 5'd8)       avm_readdata <= m_seed + 32'(avm_address);
            else                               avm_readdata <= 32'h0;
        end
    end

    int           cyc = 0;
    int           n_load = 0, n_start = 0, n_srst = 0, n_ack = 0, n_pop = 0, n_push = 0;
    int           ld_idx = 0, start_cyc = 0, load0_cyc = 0, hv_cyc = 0, accept_cyc = 0;
    logic         hv_prev = 1'b0;
    logic [511:0] cur_blk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset_n) begin
            ld_idx  = 0;
            hv_prev = 1'b0;
        end else begin
            if (avm_write) begin
                check("cs_on_write", 256'(avm_chipselect), 256'(1));
                if (avm_address < 5'd16) begin
                    if (ld_idx == 0) load0_cyc = cyc;
                    check("load_addr", 256'(avm_address), 256'(ld_idx));
                    check("load_data", 256'(avm_writedata), 256'(cur_blk[ld_idx*32 +: 32]));
                    ld_idx = (ld_idx + 1) % 16;
                    n_load++;
                end else if (avm_address == ACC_ADDR_CTRL) begin
                    if (avm_writedata == CTRL_START) begin
                        n_start++;
                        start_cyc = cyc;
                    end else if (avm_writedata == CTRL_SOFT_RST) n_srst++;
                    else if (avm_writedata == CTRL_ACK)          n_ack++;
                    else check("ctrl_word", 256'(avm_writedata), 256'(CTRL_START));
                end else begin
                    check("write_addr", 256'(avm_address), 256'(ACC_ADDR_CTRL));
                end
            end else if (avm_chipselect) begin
                check("cs_without_write", 256'(avm_chipselect), 256'(0));
            end
            if (hash_valid && !hv_prev) hv_cyc = cyc;
            hv_prev = hash_valid;
            if (hash_valid && hash_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_hash", 256'(1), 256'(0));
                end else begin
                    sb_e = exp_q.pop_front();
                    check("hash_data", hash_data, sb_e.hash);
                    check("hash_err", 256'(hash_err), 256'(sb_e.err));
                end
                n_pop++;
            end
        end
    end

    int s_load, s_start, s_srst, s_ack;
    bit found;

    task automatic snap();
        s_load  = n_load;
        s_start = n_start;
        s_srst  = n_srst;
        s_ack   = n_ack;
    endtask

    task automatic offer(input logic [511:0] b, input logic [31:0] seed, input bit err,
                         input int lat, input int hang_until);
        exp_t e;
        bit   ok;
        m_lat        = lat;
        m_seed       = seed;
        m_hang_until = hang_until;
        cur_blk      = b;
        e.hash       = err ? '0 : mk_hash(seed);
        e.err        = err;
        exp_q.push_back(e);
        n_push++;
        @(posedge clk); #1;
        blk_data  = b;
        blk_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (blk_ready) begin
                ok = 1'b1;
                break;
            end
        end
        accept_cyc = cyc;
        check("blk_accept", 256'(ok), 256'(1));
        @(posedge clk); #1;
        blk_valid = 1'b0;
    endtask

    task automatic wait_pops(input int target, input int budget);
        int i = 0;
        while (n_pop < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("job_done", 256'(n_pop >= target), 256'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        blk_valid    = 1'b0;
        blk_data     = '0;
        hash_ready   = 1'b1;
        m_seed       = '0;
        m_lat        = 0;
        m_hang_until = 0;
        cur_blk      = '0;

        repeat (3) @(negedge clk);
        check("rst_blk_ready", 256'(blk_ready), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_hash_valid", 256'(hash_valid), 256'(0));
        check("rst_avm_write", 256'(avm_write), 256'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_blk_ready", 256'(blk_ready), 256'(1));
        check("idle_busy", 256'(busy), 256'(0));
        check("idle_hash_err", 256'(hash_err), 256'(0));
        check("idle_hash_data", hash_data, 256'(0));
        check("idle_avm_addr", 256'(avm_address), 256'(0));
        check("idle_avm_wdata", 256'(avm_writedata), 256'(0));

        // Nominal job: 16+1 writes, 22 polls, 9+1+2, 1 into OUT
        snap();
        offer(mk_blk(32'h1000_0000), 32'hA5A5_0000, 1'b0, 20, 0);
        wait_pops(n_push, 400);
        check("nom_loads", 256'(n_load - s_load), 256'(16));
        check("nom_starts", 256'(n_start - s_start), 256'(1));
        check("nom_srst", 256'(n_srst - s_srst), 256'(0));
        check("nom_acks", 256'(n_ack - s_ack), 256'(1));
        check("nom_start_gap", 256'(start_cyc - load0_cyc), 256'(16));
        check("nom_latency", 256'(hv_cyc - accept_cyc), 256'(52));

        // Back-pressure with a second block offered while the first waits in OUT
        hash_ready = 1'b0;
        offer(mk_blk(32'h2000_0000), 32'hB0B0_0000, 1'b0, 10, 0);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (hash_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("bp_hash_valid", 256'(found), 256'(1));
        m_seed  = 32'hC3C3_0000;
        m_lat   = 5;
        cur_blk = mk_blk(32'h3000_0000);
        sb_e.hash = mk_hash(32'hC3C3_0000);
        sb_e.err  = 1'b0;
        exp_q.push_back(sb_e);
        n_push++;
        @(posedge clk); #1;
        blk_data  = cur_blk;
        blk_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_hash_stable", hash_data, mk_hash(32'hB0B0_0000));
            check("bp_valid_hold", 256'(hash_valid), 256'(1));
            check("bp_blk_ready", 256'(blk_ready), 256'(0));
        end
        @(posedge clk); #1;
        hash_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_at_hs", 256'(blk_ready), 256'(0));
        @(negedge clk);
        check("bp_accept_next", 256'(blk_ready), 256'(1));
        @(posedge clk); #1;
        blk_valid = 1'b0;
        @(negedge clk);
        check("bp_busy_after", 256'(busy), 256'(1));
        wait_pops(n_push, 400);

        // Single hang: first START ignored, recovered without reload
        snap();
        offer(mk_blk(32'h4000_0000), 32'hD4D4_0000, 1'b0, 12, m_start_total + 1);
        wait_pops(n_push, 600);
        check("hang1_starts", 256'(n_start - s_start), 256'(2));
        check("hang1_srst", 256'(n_srst - s_srst), 256'(1));
        check("hang1_loads", 256'(n_load - s_load), 256'(16));
        check("hang1_acks", 256'(n_ack - s_ack), 256'(1));

        // Permanent hang: retries exhausted
        snap();
        offer(mk_blk(32'h5000_0000), 32'h0, 1'b1, 12, 32'h4000_0000);
        wait_pops(n_push, 1000);
        check("hangp_starts", 256'(n_start - s_start), 256'(RETRIES + 1));
        check("hangp_srst", 256'(n_srst - s_srst), 256'(RETRIES + 1));
        check("hangp_acks", 256'(n_ack - s_ack), 256'(0));
        check("hangp_loads", 256'(n_load - s_load), 256'(16));

        // Boundary: DONE seen on exactly the TIMEOUT-th poll cycle
        snap();
        offer(mk_blk(32'h6000_0000), 32'hE6E6_0000, 1'b0, TIMEOUT - 2, 0);
        wait_pops(n_push, 600);
        check("bnd_srst", 256'(n_srst - s_srst), 256'(0));
        check("bnd_starts", 256'(n_start - s_start), 256'(1));
        check("bnd_latency", 256'(hv_cyc - accept_cyc), 256'(TIMEOUT + 30));

        // Mid-job reset during LOAD word 7
        snap();
        offer(mk_blk(32'h7000_0000), 32'hF7F7_0000, 1'b0, 10, 0);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (avm_write && avm_address == 5'd7) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_saw_word7", 256'(found), 256'(1));
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        n_push--;
        @(negedge clk);
        check("mid_busy", 256'(busy), 256'(0));
        check("mid_avm_write", 256'(avm_write), 256'(0));
        check("mid_avm_cs", 256'(avm_chipselect), 256'(0));
        check("mid_avm_addr", 256'(avm_address), 256'(0));
        check("mid_avm_wdata", 256'(avm_writedata), 256'(0));
        check("mid_hash_valid", 256'(hash_valid), 256'(0));
        check("mid_hash_err", 256'(hash_err), 256'(0));
        check("mid_hash_data", hash_data, 256'(0));
        check("mid_blk_ready", 256'(blk_ready), 256'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_ready_after", 256'(blk_ready), 256'(1));
        offer(mk_blk(32'h8000_0000), 32'h1818_0000, 1'b0, 10, 0);
        wait_pops(n_push, 400);
        check("mid_loads", 256'(n_load - s_load), 256'(24));
        check("mid_starts", 256'(n_start - s_start), 256'(1));
        check("mid_acks", 256'(n_ack - s_ack), 256'(1));
        check("queue_empty", 256'(exp_q.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
